// File: rtl/i2c_slave_rx_fsm.sv
// I2C slave receive controller: START/STOP detect, address/data shift, ACK drive.
// Define I2C_GENERAL_CALL_EN to also answer the general-call address 7'h00 (write only).
module i2c_slave_rx_fsm #(
    parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       SCL_sync,
    input  logic       SDA_sync,
    input  logic       rising_edge,
    input  logic       falling_edge,
    input  logic       rx_ready,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       rw_mode,
    output logic       tx_handoff,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_HANDOFF, S_IGNORE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sda_prev;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_drive, w_drive_nxt;
    logic [7:0]  r_rx_data, w_rx_data_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_handoff, w_handoff_nxt;
    logic        r_overrun, w_overrun_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_rx_valid, w_addr_match;
    logic        w_start, w_stop, w_byte_end, w_gc, w_addr_hit;

    assign w_start    = SCL_sync & r_sda_prev & ~SDA_sync;
    assign w_stop     = SCL_sync & ~r_sda_prev & SDA_sync;
    assign w_byte_end = falling_edge & (r_bitcnt == 4'd8);

`ifdef I2C_GENERAL_CALL_EN
    assign w_gc = (r_shift == 8'h00);
`else
    assign w_gc = 1'b0;
`endif

    assign w_addr_hit = (r_shift[7:1] == SLAVE_ADDR) | w_gc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_sda_prev <= 1'b0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_drive    <= 1'b0;
            r_rx_data  <= '0;
            r_rw       <= 1'b0;
            r_handoff  <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sda_prev <= SDA_sync;
            r_shift    <= w_shift_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_drive    <= w_drive_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rw       <= w_rw_nxt;
            r_handoff  <= w_handoff_nxt;
            r_overrun  <= w_overrun_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bitcnt_nxt  = r_bitcnt;
        w_drive_nxt   = r_drive;
        w_rx_data_nxt = r_rx_data;
        w_rw_nxt      = r_rw;
        w_handoff_nxt = r_handoff;
        w_overrun_nxt = r_overrun;
        w_busy_nxt    = r_busy;
        w_rx_valid    = 1'b0;
        w_addr_match  = 1'b0;
        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bitcnt_nxt  = '0;
            w_busy_nxt    = 1'b1;
            w_drive_nxt   = 1'b0;
            w_handoff_nxt = 1'b0;
            w_overrun_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_drive_nxt   = 1'b0;
            w_handoff_nxt = 1'b0;
        end else begin
            // Only address and data bits are captured; ACK clocks are skipped.
            if (rising_edge && (r_state == S_ADDR || r_state == S_DATA)
                && r_bitcnt != 4'd8) begin
                w_shift_nxt  = {r_shift[6:0], SDA_sync};
                w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
            case (r_state)
                S_ADDR: begin
                    if (w_byte_end) begin
                        if (w_addr_hit) begin
                            w_state_nxt  = S_ADDR_ACK;
                            w_drive_nxt  = 1'b1;
                            w_addr_match = 1'b1;
                            w_rw_nxt     = r_shift[0];
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (falling_edge) begin
                        w_drive_nxt  = 1'b0;
                        w_bitcnt_nxt = '0;
                        if (r_rw) begin
                            w_state_nxt   = S_HANDOFF;
                            w_handoff_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_byte_end) begin
                        w_state_nxt = S_DATA_ACK;
                        if (rx_ready) begin
                            w_rx_data_nxt = r_shift;
                            w_rx_valid    = 1'b1;
                            w_drive_nxt   = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                            w_drive_nxt   = 1'b0;
                        end
                    end
                end
                S_DATA_ACK: begin
                    // Drive level during the ACK slot records accept vs NACK.
                    if (falling_edge) begin
                        w_drive_nxt  = 1'b0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = r_drive ? S_DATA : S_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_drive_low = r_drive;
    assign rx_data       = w_rx_valid ? r_shift : r_rx_data;
    assign rx_valid      = w_rx_valid;
    assign addr_match    = w_addr_match;
    assign rw_mode       = r_rw;
    assign tx_handoff    = r_handoff;
    assign overrun       = r_overrun;
    assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx_fsm.sv
// Randomized bus-level bench for i2c_slave_rx_fsm with a transaction-level model
// and a pulse scoreboard (honours I2C_GENERAL_CALL_EN when defined).
module tb_i2c_slave_rx_fsm;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       SCL_sync = 1'b1;
    logic       SDA_sync = 1'b1;
    logic       rising_edge = 1'b0;
    logic       falling_edge = 1'b0;
    logic       rx_ready = 1'b1;
    logic       sda_drive_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       rw_mode;
    logic       tx_handoff;
    logic       overrun;
    logic       busy;

    i2c_slave_rx_fsm #(.SLAVE_ADDR(7'h48)) dut (
        .clk(clk), .n_rst(n_rst),
        .SCL_sync(SCL_sync), .SDA_sync(SDA_sync),
        .rising_edge(rising_edge), .falling_edge(falling_edge),
        .rx_ready(rx_ready), .sda_drive_low(sda_drive_low),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .addr_match(addr_match), .rw_mode(rw_mode),
        .tx_handoff(tx_handoff), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    logic [7:0] m_last = 8'h00;
    logic       m_over = 1'b0;
    logic [7:0] td[4];
    bit         tr[4];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every address/data pulse must match the queue head.
    always @(negedge clk) begin
        if (n_rst && (addr_match || rx_valid)) begin
            if (exp_q.size() == 0) begin
                chk1("unexpected_pulse", addr_match | rx_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind) begin
                    chk1("rx_valid", rx_valid, 1'b1);
                    chk8("rx_data", rx_data, mon_e.data);
                end else begin
                    chk1("addr_match", addr_match, 1'b1);
                end
            end
        end
    end

    task automatic set(input logic scl, input logic sda, input logic re, input logic fe);
        SCL_sync = scl;
        SDA_sync = sda;
        rising_edge = re;
        falling_edge = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        set(1'b0, b, 1'b0, 1'b0);
        set(1'b1, b, 1'b1, 1'b0);
        set(1'b1, b, 1'b0, 1'b0);
        set(1'b0, b, 1'b0, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ack_bit(input string name, input logic exp);
        set(1'b0, 1'b1, 1'b0, 1'b0);
        set(1'b1, 1'b1, 1'b1, 1'b0);
        chk1(name, sda_drive_low, exp);
        set(1'b1, 1'b1, 1'b0, 1'b0);
        set(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic start_c();
        set(1'b0, 1'b1, 1'b0, 1'b0);
        set(1'b1, 1'b1, 1'b0, 1'b0);
        set(1'b1, 1'b0, 1'b0, 1'b0);
        set(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic stop_c();
        set(1'b0, 1'b0, 1'b0, 1'b0);
        set(1'b1, 1'b0, 1'b0, 1'b0);
        set(1'b1, 1'b1, 1'b0, 1'b0);
        set(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // One transfer: START, address, n data bytes (td/tr), optional STOP.
    task automatic xfer(input logic [7:0] a, input int n, input bit end_stop);
        bit match, rd, ign, acc;
        match = (a[7:1] == 7'h48);
`ifdef I2C_GENERAL_CALL_EN
        if (a == 8'h00) match = 1'b1;
`endif
        rd = match & a[0];
        start_c();
        m_over = 1'b0;
        chk1("busy_start", busy, 1'b1);
        chk1("overrun_clr", overrun, 1'b0);
        if (match) exp_q.push_back(ev_t'{kind: 1'b0, data: 8'h00});
        send_byte(a);
        ack_bit("addr_ack", match);
        if (match) chk1("rw_mode", rw_mode, a[0]);
        chk1("tx_handoff", tx_handoff, rd);
        ign = !match || rd;
        for (int i = 0; i < n; i++) begin
            rx_ready = tr[i];
            acc = !ign && tr[i];
            if (acc) begin
                exp_q.push_back(ev_t'{kind: 1'b1, data: td[i]});
                m_last = td[i];
            end
            send_byte(td[i]);
            ack_bit("data_ack", acc);
            if (!ign && !tr[i]) begin
                m_over = 1'b1;
                ign = 1'b1;
            end
            chk1("overrun", overrun, m_over);
            chk1("handoff_hold", tx_handoff, rd);
        end
        rx_ready = 1'b1;
        chk8("rx_data_hold", rx_data, m_last);
        if (end_stop) begin
            stop_c();
            chk1("busy_stop", busy, 1'b0);
            chk1("handoff_stop", tx_handoff, 1'b0);
            chk1("overrun_sticky", overrun, m_over);
        end
    endtask

    initial begin
        logic [7:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_drive", sda_drive_low, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_handoff", tx_handoff, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_rw", rw_mode, 1'b0);
        chk8("rst_rx_data", rx_data, 8'h00);
        n_rst = 1'b1;
        set(1'b1, 1'b1, 1'b0, 1'b0);
        set(1'b1, 1'b1, 1'b0, 1'b0);

        td[0] = 8'hA5; tr[0] = 1'b1;
        xfer(8'h90, 1, 1'b1);
        td[0] = 8'h11; tr[0] = 1'b1;
        xfer(8'h91, 1, 1'b1);
        td[0] = 8'h22; td[1] = 8'h33; tr[0] = 1'b1; tr[1] = 1'b1;
        xfer(8'h52, 2, 1'b1);
        td[0] = 8'h3C; td[1] = 8'h55; tr[0] = 1'b0; tr[1] = 1'b1;
        xfer(8'h90, 2, 1'b0);
        td[0] = 8'h77; tr[0] = 1'b1;
        xfer(8'h90, 1, 1'b1);

        start_c();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        stop_c();
        chk1("partial_busy", busy, 1'b0);
        chk8("partial_rx_data", rx_data, m_last);

        start_c();
        exp_q.push_back(ev_t'{kind: 1'b0, data: 8'h00});
        send_byte(8'h90);
        chk1("pre_rst_drive", sda_drive_low, 1'b1);
        n_rst = 1'b0;
        #1;
        chk1("async_rst_drive", sda_drive_low, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        m_last = 8'h00;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        stop_c();

        td[0] = 8'h5A; tr[0] = 1'b1;
        xfer(8'h00, 1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: a = 8'h90;
                1: a = 8'h91;
                2: a = 8'h52;
                3: a = 8'h00;
                default: a = 8'($urandom);
            endcase
            for (int i = 0; i < 4; i++) begin
                td[i] = 8'($urandom);
                tr[i] = ($urandom_range(0, 3) != 0);
            end
            xfer(a, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) || t == 39);
        end

        repeat (4) set(1'b1, 1'b1, 1'b0, 1'b0);
        chk8("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
